// File: rtl/mcycle_seq85_if.sv
// Bus bundle between the 8085-class cycle sequencer and its environment
// (decoder handshake, external bus strobes and status lines).
interface mcycle_seq85_if;
    logic [7:0] inDATA;
    logic       inREADY;
    logic [2:0] inMCNT;
    logic       inM1LONG;
    logic [1:0] inMTYPE;
    logic       inHALT;
    logic       inINTR;
    logic [7:0] outOPC;
    logic       outOPCV;
    logic [2:0] outMCYC;
    logic [2:0] outTST;
    logic       outALE;
    logic       outRD;
    logic       outWR;
    logic       outIOM;
    logic [1:0] outS;
    logic       outMDONE;
    logic       outIDONE;
    logic       outHLTA;

    modport master (
        input  inDATA, inREADY, inMCNT, inM1LONG, inMTYPE, inHALT, inINTR,
        output outOPC, outOPCV, outMCYC, outTST, outALE, outRD, outWR,
               outIOM, outS, outMDONE, outIDONE, outHLTA
    );

    modport slave (
        output inDATA, inREADY, inMCNT, inM1LONG, inMTYPE, inHALT, inINTR,
        input  outOPC, outOPCV, outMCYC, outTST, outALE, outRD, outWR,
               outIOM, outS, outMDONE, outIDONE, outHLTA
    );
endinterface

// File: rtl/mcycle_seq85.sv
// Machine-cycle / T-state sequencer: fetches opcodes in M1, then walks the
// decoder-supplied M2..Mn cycles with wait states and halt handling.
module mcycle_seq85 #(
    parameter int unsigned MAXM = 5
) (
    input  logic           inCLK,
    input  logic           inRST,
    mcycle_seq85_if.master bus
);

    typedef enum logic [3:0] {
        ST_IDLE, ST_T1, ST_T2, ST_TW, ST_T3, ST_T4, ST_T5, ST_T6, ST_HALT
    } state_e;

    localparam logic [2:0] MAXM_L = 3'(MAXM);

    state_e     state_q, state_d;
    logic [2:0] mcyc_q, mcyc_d;
    logic [2:0] cnt_q, cnt_d;
    logic       long_q, long_d;
    logic [7:0] opc_q, opc_d;
    logic [1:0] mtype_q, mtype_d;

    logic [2:0] cnt_clamp;
    logic [1:0] cyc_type;
    logic       is_m1;
    logic       instr_end;

    always_comb begin
        if (bus.inMCNT == 3'd0)       cnt_clamp = 3'd1;
        else if (bus.inMCNT > MAXM_L) cnt_clamp = MAXM_L;
        else                          cnt_clamp = bus.inMCNT;
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of all the others.
    always_ff @(posedge inCLK) begin
        if (inRST) begin
            state_q <= ST_IDLE;
            mcyc_q  <= 3'd0;
            cnt_q   <= 3'd1;
            long_q  <= 1'b0;
            opc_q   <= 8'h00;
            mtype_q <= 2'b00;
        end else begin
            state_q <= state_d;
            mcyc_q  <= mcyc_d;
            cnt_q   <= cnt_d;
            long_q  <= long_d;
            opc_q   <= opc_d;
            mtype_q <= mtype_d;
        end
    end

    always_comb begin
        // NOTE: every signal written here gets a default first, so no branch
        // can leave one unassigned and infer a latch.
        state_d      = state_q;
        mcyc_d       = mcyc_q;
        cnt_d        = cnt_q;
        long_d       = long_q;
        opc_d        = opc_q;
        mtype_d      = mtype_q;
        instr_end    = 1'b0;
        bus.outOPC   = opc_q;
        bus.outOPCV  = 1'b0;
        bus.outMCYC  = 3'd0;
        bus.outTST   = 3'd0;
        bus.outALE   = 1'b0;
        bus.outRD    = 1'b0;
        bus.outWR    = 1'b0;
        bus.outIOM   = 1'b0;
        bus.outS     = 2'b00;
        bus.outMDONE = 1'b0;
        bus.outIDONE = 1'b0;
        bus.outHLTA  = 1'b0;

        is_m1    = (mcyc_q == 3'd1);
        // The cycle type is live on the bus during T1 and held from then on.
        cyc_type = (state_q == ST_T1) ? bus.inMTYPE : mtype_q;

        case (state_q)
            ST_IDLE: begin
                state_d = ST_T1;
                mcyc_d  = 3'd1;
            end
            ST_T1: begin
                bus.outTST = 3'd1;
                bus.outALE = 1'b1;
                if (!is_m1) mtype_d = bus.inMTYPE;
                state_d = ST_T2;
            end
            ST_T2: begin
                bus.outTST = 3'd2;
                state_d    = bus.inREADY ? ST_T3 : ST_TW;
            end
            ST_TW: begin
                bus.outTST = 3'd7;
                if (bus.inREADY) state_d = ST_T3;
            end
            ST_T3: begin
                bus.outTST = 3'd3;
                if (is_m1) begin
                    opc_d   = bus.inDATA;
                    state_d = ST_T4;
                end else begin
                    bus.outMDONE = 1'b1;
                    instr_end    = (mcyc_q == cnt_q);
                    if (!instr_end) begin
                        mcyc_d  = mcyc_q + 3'd1;
                        state_d = ST_T1;
                    end
                end
            end
            ST_T4: begin
                bus.outTST  = 3'd4;
                bus.outOPCV = 1'b1;
                cnt_d       = cnt_clamp;
                long_d      = bus.inM1LONG;
                if (bus.inM1LONG) begin
                    state_d = ST_T5;
                end else begin
                    bus.outMDONE = 1'b1;
                    instr_end    = (cnt_clamp == 3'd1);
                    if (!instr_end) begin
                        mcyc_d  = 3'd2;
                        state_d = ST_T1;
                    end
                end
            end
            ST_T5: begin
                bus.outTST = 3'd5;
                state_d    = ST_T6;
            end
            ST_T6: begin
                bus.outTST   = 3'd6;
                bus.outMDONE = 1'b1;
                instr_end    = (cnt_q == 3'd1);
                if (!instr_end) begin
                    mcyc_d  = 3'd2;
                    state_d = ST_T1;
                end
            end
            ST_HALT: begin
                bus.outHLTA = 1'b1;
                if (bus.inINTR) begin
                    state_d = ST_T1;
                    mcyc_d  = 3'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                mcyc_d  = 3'd0;
            end
        endcase

        if (instr_end) begin
            bus.outIDONE = 1'b1;
            if (bus.inHALT) begin
                state_d = ST_HALT;
                mcyc_d  = 3'd0;
            end else begin
                state_d = ST_T1;
                mcyc_d  = 3'd1;
            end
        end

        if (state_q != ST_IDLE && state_q != ST_HALT) begin
            bus.outMCYC = mcyc_q;
            if (is_m1) begin
                bus.outS  = 2'b11;
                bus.outRD = (state_q == ST_T2 || state_q == ST_TW || state_q == ST_T3);
            end else begin
                bus.outIOM = cyc_type[1];
                bus.outS   = cyc_type[0] ? 2'b01 : 2'b10;
                if (state_q == ST_T2 || state_q == ST_TW || state_q == ST_T3) begin
                    bus.outRD = !cyc_type[0];
                    bus.outWR = cyc_type[0];
                end
            end
        end
    end

endmodule

// File: tb/tb_mcycle_seq85.sv
// Self-checking bench for mcycle_seq85: each instruction is expanded into an
// expected per-cycle bus trace from its cycle count, types and wait states.
module tb_mcycle_seq85;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_errors = 0;
    logic [7:0] exp_opc = 8'h00;

    mcycle_seq85_if bus ();

    mcycle_seq85 #(.MAXM(5)) dut (
        .inCLK (clk),
        .inRST (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0] tst;
        logic [2:0] mcyc;
        logic       ale, rd, wr, iom;
        logic [1:0] s;
        logic       s_care;
        logic       mdone, idone, opcv, hlta;
        logic [7:0] opc;
        logic       ready;
        logic [1:0] mtype;
        logic       m1t3;
        logic       last;
    } row_t;

    row_t       q[$];
    logic [1:0] ty_a [6];
    int         w_a  [6];

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    function automatic row_t blank(input logic [7:0] opc);
        row_t r;
        r = '{tst: 3'd0, mcyc: 3'd0, ale: 1'b0, rd: 1'b0, wr: 1'b0, iom: 1'b0,
              s: 2'b00, s_care: 1'b1, mdone: 1'b0, idone: 1'b0, opcv: 1'b0,
              hlta: 1'b0, opc: opc, ready: 1'($urandom), mtype: 2'($urandom),
              m1t3: 1'b0, last: 1'b0};
        return r;
    endfunction

    task automatic check_row(input string tag, input row_t r);
        chk({tag, " tst"}, 8'(bus.outTST), 8'(r.tst));
        chk({tag, " mcyc"}, 8'(bus.outMCYC), 8'(r.mcyc));
        chk({tag, " ale"}, 8'(bus.outALE), 8'(r.ale));
        chk({tag, " rd"}, 8'(bus.outRD), 8'(r.rd));
        chk({tag, " wr"}, 8'(bus.outWR), 8'(r.wr));
        chk({tag, " iom"}, 8'(bus.outIOM), 8'(r.iom));
        if (r.s_care) chk({tag, " s"}, 8'(bus.outS), 8'(r.s));
        chk({tag, " mdone"}, 8'(bus.outMDONE), 8'(r.mdone));
        chk({tag, " idone"}, 8'(bus.outIDONE), 8'(r.idone));
        chk({tag, " opcv"}, 8'(bus.outOPCV), 8'(r.opcv));
        chk({tag, " hlta"}, 8'(bus.outHLTA), 8'(r.hlta));
        chk({tag, " opc"}, bus.outOPC, r.opc);
    endtask

    // One bus cycle: T1, T2, waits, T3. The strobe, status and wait rules are
    // common to M1 and Mn; only what they drive differs.
    task automatic add_bus_cycle(input int n, input int eff, input logic [7:0] opc_old);
        row_t r;
        logic m1;
        m1 = (n == 1);
        r = blank(opc_old);
        r.mcyc  = 3'(n);
        r.mtype = m1 ? 2'($urandom) : ty_a[n];
        r.iom   = m1 ? 1'b0 : ty_a[n][1];
        r.s     = m1 ? 2'b11 : (ty_a[n][0] ? 2'b01 : 2'b10);
        r.tst = 3'd1; r.ale = 1'b1;
        q.push_back(r);
        r.ale = 1'b0;
        r.rd  = m1 ? 1'b1 : !ty_a[n][0];
        r.wr  = m1 ? 1'b0 : ty_a[n][0];
        r.tst = 3'd2; r.ready = (w_a[n] == 0);
        q.push_back(r);
        for (int i = 1; i <= w_a[n]; i++) begin
            r.tst = 3'd7; r.ready = (i == w_a[n]);
            q.push_back(r);
        end
        r.tst = 3'd3; r.ready = 1'($urandom);
        r.m1t3  = m1;
        r.mdone = !m1;
        r.idone = !m1 && (n == eff);
        r.last  = r.idone;
        q.push_back(r);
    endtask

    task automatic build(input logic [7:0] opc, input logic [2:0] mcnt, input logic lng);
        row_t r;
        int eff;
        eff = (mcnt == 0) ? 1 : ((mcnt > 5) ? 5 : int'(mcnt));
        q.delete();
        add_bus_cycle(1, eff, exp_opc);
        r = blank(opc);
        r.mcyc = 3'd1; r.s_care = 1'b0;
        r.tst = 3'd4; r.opcv = 1'b1;
        r.mdone = !lng; r.idone = !lng && (eff == 1); r.last = r.idone;
        q.push_back(r);
        if (lng) begin
            r.opcv = 1'b0;
            r.tst = 3'd5;
            q.push_back(r);
            r.tst = 3'd6; r.mdone = 1'b1; r.idone = (eff == 1); r.last = r.idone;
            q.push_back(r);
        end
        for (int n = 2; n <= eff; n++) add_bus_cycle(n, eff, opc);
    endtask

    task automatic play(input string name, input logic [7:0] opc, input logic [2:0] mcnt,
                        input logic lng, input logic halt, input int halt_len, input int abort_at);
        row_t r;
        build(opc, mcnt, lng);
        foreach (q[i]) begin
            if (abort_at >= 0 && i > abort_at) break;
            @(negedge clk);
            bus.inREADY  = q[i].ready;
            bus.inMTYPE  = q[i].mtype;
            bus.inMCNT   = mcnt;
            bus.inM1LONG = lng;
            bus.inDATA   = q[i].m1t3 ? opc : 8'($urandom);
            bus.inHALT   = q[i].last ? halt : 1'($urandom);
            bus.inINTR   = 1'($urandom);
            rst          = (i == abort_at);
            #1;
            check_row($sformatf("%s row%0d", name, i), q[i]);
        end
        if (abort_at >= 0) begin
            @(negedge clk);
            rst = 1'b0;
            bus.inINTR = 1'($urandom);
            #1;
            exp_opc = 8'h00;
            check_row($sformatf("%s reset-idle", name), blank(exp_opc));
            return;
        end
        exp_opc = opc;
        if (halt) begin
            for (int k = 0; k <= halt_len; k++) begin
                @(negedge clk);
                bus.inINTR  = (k == halt_len);
                bus.inHALT  = 1'($urandom);
                bus.inREADY = 1'($urandom);
                #1;
                r = blank(exp_opc);
                r.hlta = 1'b1;
                check_row($sformatf("%s halt%0d", name, k), r);
            end
        end
    endtask

    task automatic set_all(input logic [1:0] ty, input int w);
        for (int n = 0; n < 6; n++) begin
            ty_a[n] = ty;
            w_a[n]  = w;
        end
    endtask

    initial begin
        bus.inDATA = 8'h00; bus.inREADY = 1'b1; bus.inMCNT = 3'd1;
        bus.inM1LONG = 1'b0; bus.inMTYPE = 2'b00; bus.inHALT = 1'b0; bus.inINTR = 1'b0;
        set_all(2'b00, 0);

        @(negedge clk); #1;
        check_row("reset a", blank(8'h00));
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_row("reset b", blank(8'h00));

        play("t1 nop a", 8'h00, 3'd1, 1'b0, 1'b0, 0, -1);
        play("t1 nop b", 8'h00, 3'd1, 1'b0, 1'b0, 0, -1);

        set_all(2'b00, 0);
        play("t2 lda", 8'h3A, 3'd4, 1'b0, 1'b0, 0, -1);

        set_all(2'b01, 0);
        play("t3 push", 8'hC5, 3'd3, 1'b1, 1'b0, 0, -1);

        set_all(2'b10, 0);
        w_a[2] = 3;
        play("t4 in wait", 8'hDB, 3'd2, 1'b0, 1'b0, 0, -1);

        set_all(2'b00, 0);
        play("t5 hlt", 8'h76, 3'd1, 1'b0, 1'b1, 3, -1);

        // Row 8 is M3 T2 of a three-cycle write with no waits.
        set_all(2'b01, 0);
        play("t6 abort", 8'h22, 3'd3, 1'b0, 1'b0, 0, 8);

        set_all(2'b00, 0);
        play("clamp0", 8'h11, 3'd0, 1'b0, 1'b0, 0, -1);
        set_all(2'b11, 1);
        play("clamp7", 8'h12, 3'd7, 1'b1, 1'b0, 0, -1);

        for (int t = 0; t < 60; t++) begin
            logic [2:0] mcnt;
            logic       lng, halt;
            mcnt = 3'($urandom_range(0, 7));
            lng  = 1'($urandom);
            halt = ($urandom_range(0, 5) == 0);
            for (int n = 0; n < 6; n++) begin
                ty_a[n] = 2'($urandom);
                w_a[n]  = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 3)) : 0;
            end
            play($sformatf("rnd%0d", t), 8'($urandom), mcnt, lng, halt,
                 int'($urandom_range(0, 3)), -1);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
